// File: rtl/frame_pingpong_buffer.sv
// frame_pingpong_buffer: two-bank frame store; the writer fills the back bank, the reader swaps it to the front at a frame boundary.
//   clk, rst (async, active-high); wr_en/wr_addr/wr_data write the back bank; wr_frame_done marks a full back frame;
//   rd_frame_start marks a reader frame boundary; rd_addr/rd_data read the front bank with one-cycle latency;
//   front_sel, frame_pending, wr_err, drop_cnt report status. Define FB_DROP_COUNT_EN to enable the dropped-frame counter.
module frame_pingpong_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_sel,
  output logic              frame_pending,
  output logic              wr_err,
  output logic [7:0]        drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  typedef enum logic {WRITING, PENDING} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic wr_in, rd_in, wr_ok, swap;
  assign wr_in = {1'b0, wr_addr} < LIM;
  assign rd_in = {1'b0, rd_addr} < LIM;
  assign wr_ok = wr_en && wr_in && state == WRITING;
  assign frame_pending = state == PENDING;
  always_comb begin
    swap = state == PENDING && rd_frame_start;
    state_d = swap ? WRITING : (state == WRITING && wr_frame_done) ? PENDING : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WRITING;
      front_sel <= 1'b0;
      wr_err <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_d;
      front_sel <= front_sel ^ swap;
      wr_err <= wr_en && !wr_ok;
      rd_data <= rd_in ? mem[front_sel][rd_addr[AW-1:0]] : '0;
    end
  end
  // bank storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[~front_sel][wr_addr[AW-1:0]] <= wr_data;
  end
`ifdef FB_DROP_COUNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else if (state == PENDING && wr_frame_done && !rd_frame_start && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_pingpong_buffer.sv
// tb_frame_pingpong_buffer: randomized and directed checks of frame_pingpong_buffer against a frame-level reference model.
module tb_frame_pingpong_buffer;
  localparam int DW = 16, AW = 8, DP = 100;
`ifdef FB_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, wr_frame_done = 1'b0, rd_frame_start = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic front_sel, frame_pending, wr_err;
  logic [7:0] drop_cnt;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] m_bank [2][DP];
  int m_front, m_drop;
  bit m_pend, m_err;
  logic [DW-1:0] m_rd;

  frame_pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start), .rd_addr(rd_addr),
    .rd_data(rd_data), .front_sel(front_sel), .frame_pending(frame_pending),
    .wr_err(wr_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
    chk({tag, ".front_sel"}, 32'(front_sel), 32'(m_front));
    chk({tag, ".pending"}, 32'(frame_pending), 32'(m_pend));
    chk({tag, ".wr_err"}, 32'(wr_err), 32'(m_err));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic model_reset();
    m_front = 0; m_pend = 0; m_err = 0; m_drop = 0; m_rd = '0;
  endtask

  // one clock: apply the frame rules to the current inputs, then compare after the edge
  task automatic cycle(input string tag);
    bit in_range;
    in_range = int'(wr_addr) < DP;
    m_rd = (int'(rd_addr) < DP) ? m_bank[m_front][rd_addr] : '0;
    m_err = wr_en && (!in_range || m_pend);
    if (wr_en && in_range && !m_pend) m_bank[1-m_front][wr_addr] = wr_data;
    if (!m_pend) m_pend = wr_frame_done;
    else if (rd_frame_start) begin m_front = 1 - m_front; m_pend = 0; end
    else if (wr_frame_done && DROP_EN && m_drop < 255) m_drop++;
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  task automatic idle();
    wr_en = 0; wr_frame_done = 0; rd_frame_start = 0;
  endtask

  task automatic write(input int a, input logic [DW-1:0] d, input string tag);
    idle(); wr_en = 1; wr_addr = AW'(a); wr_data = d; cycle(tag); idle();
  endtask

  task automatic pulse(input bit done, input bit start, input string tag);
    idle(); wr_frame_done = done; rd_frame_start = start; cycle(tag); idle();
  endtask

  // reset asserted between clock edges; outputs must clear before any edge
  task automatic async_reset(input string tag);
    idle(); rst = 1; #2; model_reset();
    chk_all({tag, ".imm"});
    @(posedge clk); #1;
    chk_all({tag, ".held"});
    rst = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 0;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DP; a++) write(a, {1'b1, 15'($urandom)}, "fill");
      pulse(1, 0, "fill_done");
      pulse(0, 1, "fill_swap");
    end
    async_reset("rst1");
    for (int a = 0; a < 4; a++) write(a, DW'(8'hA0 + a), "wr_a0");
    pulse(1, 0, "done_a0");
    pulse(0, 1, "swap_a0");
    chk("swap_front1", 32'(front_sel), 32'd1);
    rd_addr = 8'd2; cycle("rd2");
    chk("rd_a2", 32'(rd_data), 32'hA2);
    pulse(1, 1, "same_cycle");
    chk("same_pending", 32'(frame_pending), 32'd1);
    chk("same_front", 32'(front_sel), 32'd1);
    pulse(0, 1, "late_swap");
    chk("late_front", 32'(front_sel), 32'd0);
    chk("late_pending", 32'(frame_pending), 32'd0);
    pulse(1, 0, "frz_done");
    write(5, 16'h1234, "frz_wr");
    chk("frz_err", 32'(wr_err), 32'd1);
    pulse(0, 1, "frz_swap");
    rd_addr = 8'd5; cycle("frz_rd");
    chk("frz_not1234", 32'(rd_data != 16'h1234), 32'd1);
    write(DP, 16'hBEEF, "oob_wr");
    chk("oob_err", 32'(wr_err), 32'd1);
    rd_addr = 8'(DP); cycle("oob_rd");
    chk("oob_rd0", 32'(rd_data), 32'd0);
    write(DP - 1, 16'h0C0C, "edge_wr");
    chk("edge_err", 32'(wr_err), 32'd0);
    pulse(1, 0, "drop_enter");
    for (int i = 0; i < 300; i++) pulse(1, 0, "drop");
    chk("drop_sat", 32'(drop_cnt), DROP_EN ? 32'd255 : 32'd0);
    pulse(1, 1, "drop_swap");
    chk("drop_swap_pending", 32'(frame_pending), 32'd0);
    for (int i = 0; i < 2000; i++) begin
      wr_en = $urandom_range(0, 1);
      wr_addr = AW'($urandom_range(0, DP + 3));
      wr_data = DW'($urandom);
      wr_frame_done = $urandom_range(0, 7) == 0;
      rd_frame_start = $urandom_range(0, 7) == 0;
      rd_addr = AW'($urandom_range(0, DP + 3));
      cycle("rand");
    end
    idle();
    for (int a = 0; a < 3; a++) write(a, DW'(16'h5500 + a), "mid_wr");
    async_reset("rst2");
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a); cycle("post_rd");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
